serial_parity_receiver: RTL and testbench
=========================================

// Module: serial_parity_receiver
// PURPOSE
//   Receiver end of the MAC's bit-serial operand link. Shifts in frames of DATA_W data
//   bits (LSB first) plus one parity bit, checks parity with a running XOR, and presents
//   each completed word to the MAC operand input over a valid/ready handshake.
//   The single-entry output buffer allows the next frame to arrive while a word waits.
// PARAMETERS
//   DATA_W      8   data bits per frame (2..32)
//   ODD_PARITY  0   0: even parity (XOR of data+parity == 0), 1: odd parity (== 1)
// PORTS
//   clk        in   1       single clock, all state on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   sin_valid  in   1       sin_bit/sin_start qualified this cycle
//   sin_start  in   1       with sin_valid: this bit is data bit 0 of a new frame
//   sin_bit    in   1       serial data/parity bit
//   out_data   out  DATA_W  received word (stable while out_valid && !out_ready)
//   out_valid  out  1       out_data holds an unconsumed word
//   out_ready  in   1       consumer accepts word when out_valid && out_ready
//   par_err    out  1       1-cycle pulse: completed frame failed parity (word dropped)
//   frame_err  out  1       1-cycle pulse: sin_start seen mid-frame (frame restarted)
//   overrun    out  1       1-cycle pulse: good frame completed while buffer full (dropped)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, bit count=0, shift reg=0, parity acc=0,
//     out_data=0, out_valid=0, par_err=0, frame_err=0, overrun=0. Reset mid-frame
//     discards partial frame and buffered word.
//   Only cycles with sin_valid=1 advance the receiver; sin_valid=0 cycles hold all state.
//   FSM: IDLE  -- sin_valid&&sin_start: capture bit 0, acc=sin_bit, cnt=1 -> DATA
//               (sin_valid without sin_start ignored in IDLE)
//        DATA  -- each valid bit: shift into position cnt, acc^=sin_bit, cnt++;
//                 after bit DATA_W-1 -> PAR
//        PAR   -- valid bit is parity: ok = (acc^sin_bit)==ODD_PARITY -> IDLE
//   sin_start in DATA or PAR: frame_err pulse next cycle, treat bit as new bit 0 (stay DATA,
//     cnt=1). sin_start on the parity bit is a restart, not a parity bit.
//   Frame completion (PAR accept cycle), registered, visible next cycle:
//     ok && buffer free (or freed same cycle by out_valid&&out_ready): out_data=word,
//       out_valid=1. Latency: out_valid rises 1 clk after the parity bit edge.
//     ok && buffer full and not consumed same cycle: overrun=1, buffer unchanged.
//     !ok: par_err=1, buffer unchanged, no out_valid change (besides normal consume).
//   Handshake: out_valid stays high and out_data stable until out_valid&&out_ready;
//     out_valid never depends combinationally on out_ready. Back-to-back frames with
//     out_ready=1 give one word per DATA_W+1 valid bits, no bubbles required.
//   Error pulses are exactly one cycle and mutually exclusive per completion.
// CONFIGURATION
//   SPR_ERR_COUNT_EN defined: adds output err_count [7:0]; increments on each par_err,
//     frame_err or overrun pulse, saturates at 8'hFF, clears to 0 on reset only.
//   Not defined: no err_count port, no counter logic; all other behaviour identical.
// TESTING
//   1 Even parity, DATA_W=8, send 0xA5 LSB first + parity 0, out_ready=1 -> out_data=0xA5,
//     out_valid high 1 cycle, 1 clk after parity bit; no error pulses.
//   2 Send 0x3C with parity 1 (wrong) -> par_err pulse 1 cycle, out_valid stays 0.
//   3 out_ready=0, send 0x11 then 0x22 -> out_data=0x11 held, overrun pulse after 2nd frame;
//     raise out_ready -> 0x11 consumed, out_valid falls, 0x22 never appears.
//   4 sin_start after 4 data bits, then full frame 0x7E -> frame_err pulse, out_data=0x7E.
//   5 Gaps: sin_valid toggling 1/0 through frame 0x81, ODD_PARITY=1 parity bit 1 ->
//     out_data=0x81; assert rst_n=0 mid-frame -> all outputs 0 immediately.
//   6 SPR_ERR_COUNT_EN: 300 bad-parity frames -> err_count=8'hFF (saturated).

Source files
------------

// File: rtl/serial_parity_receiver.sv
// Bit-serial operand receiver: LSB-first data frames plus a parity bit, single-entry output buffer.
// Defining SPR_ERR_COUNT_EN adds a saturating 8-bit error counter output (err_count).
module serial_parity_receiver #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin_valid,
    input  logic              sin_start,
    input  logic              sin_bit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              frame_err,
    output logic              overrun
`ifdef SPR_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAR
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              acc, acc_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              par_err_n, frame_err_n, overrun_n;
    logic              frame_done, frame_ok, consume;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        acc_n       = acc;
        data_n      = out_data;
        valid_n     = out_valid;
        par_err_n   = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        frame_done  = 1'b0;
        frame_ok    = 1'b0;
        consume     = out_valid && out_ready;

        if (sin_valid) begin
            if (sin_start) begin
                // A start bit always begins a new frame; mid-frame it also flags the abandoned one.
                frame_err_n = (state != ST_IDLE);
                shreg_n     = '0;
                shreg_n[0]  = sin_bit;
                acc_n       = sin_bit;
                cnt_n       = CNT_W'(1);
                state_n     = ST_DATA;
            end else begin
                case (state)
                    ST_DATA: begin
                        shreg_n[cnt] = sin_bit;
                        acc_n        = acc ^ sin_bit;
                        if (cnt == LAST_BIT) begin
                            cnt_n   = '0;
                            state_n = ST_PAR;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                    ST_PAR: begin
                        frame_done = 1'b1;
                        frame_ok   = ((acc ^ sin_bit) == ODD_PARITY);
                        cnt_n      = '0;
                        acc_n      = 1'b0;
                        state_n    = ST_IDLE;
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end

        if (consume) begin
            valid_n = 1'b0;
        end

        if (frame_done) begin
            if (!frame_ok) begin
                par_err_n = 1'b1;
            end else if (!out_valid || consume) begin
                data_n  = shreg;
                valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            acc       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            acc       <= acc_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            par_err   <= par_err_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

`ifdef SPR_ERR_COUNT_EN
    // Counts the registered pulses, so the count trails each pulse by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if ((par_err || frame_err || overrun) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Self-checking bench for serial_parity_receiver: vector table, directed corner cases and
// randomized traffic against a frame-level reference model.
module tb_serial_parity_receiver;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sin_valid = 1'b0;
    logic              sin_start = 1'b0;
    logic              sin_bit = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data, odd_data;
    logic              out_valid, odd_valid;
    logic              par_err, frame_err, overrun;
    logic              odd_par_err, odd_frame_err, odd_overrun;
`ifdef SPR_ERR_COUNT_EN
    logic [7:0]        err_count, odd_err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_parity_receiver #(.DATA_W(DATA_W), .ODD_PARITY(1'b0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin_valid (sin_valid),
        .sin_start (sin_start),
        .sin_bit   (sin_bit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .par_err   (par_err),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef SPR_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    serial_parity_receiver #(.DATA_W(DATA_W), .ODD_PARITY(1'b1)) u_odd (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin_valid (sin_valid),
        .sin_start (sin_start),
        .sin_bit   (sin_bit),
        .out_data  (odd_data),
        .out_valid (odd_valid),
        .out_ready (out_ready),
        .par_err   (odd_par_err),
        .frame_err (odd_frame_err),
        .overrun   (odd_overrun)
`ifdef SPR_ERR_COUNT_EN
        ,
        .err_count (odd_err_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model (even parity): a frame is a list of received bits; the word and its
    // parity are computed arithmetically once DATA_W+1 bits have been collected.
    int              m_bits[DATA_W+1];
    int              m_len;
    logic            m_valid;
    logic [31:0]     m_data;
    logic            e_par, e_fe, e_ov;

    task automatic model_reset();
        m_len   = 0;
        m_valid = 1'b0;
        m_data  = 0;
        e_par   = 1'b0;
        e_fe    = 1'b0;
        e_ov    = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic s, input logic b, input logic r);
        logic consume, load;
        int   word, ones;
        consume = m_valid && r;
        load    = 1'b0;
        word    = 0;
        e_par   = 1'b0;
        e_fe    = 1'b0;
        e_ov    = 1'b0;
        if (v) begin
            if (s) begin
                e_fe      = (m_len > 0);
                m_bits[0] = int'(b);
                m_len     = 1;
            end else if (m_len > 0) begin
                m_bits[m_len] = int'(b);
                m_len++;
                if (m_len == DATA_W + 1) begin
                    ones = 0;
                    for (int i = 0; i < DATA_W; i++) begin
                        word += m_bits[i] * (1 << i);
                        ones += m_bits[i];
                    end
                    ones += m_bits[DATA_W];
                    m_len = 0;
                    if (ones % 2 != 0)            e_par = 1'b1;
                    else if (!m_valid || consume) load  = 1'b1;
                    else                          e_ov  = 1'b1;
                end
            end
        end
        if (load) begin
            m_valid = 1'b1;
            m_data  = word;
        end else if (consume) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic s, input logic b, input logic r);
        sin_valid = v;
        sin_start = s;
        sin_bit   = b;
        out_ready = r;
        model_update(v, s, b, r);
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  m_data);
        check("par_err",   32'(par_err),   32'(e_par));
        check("frame_err", 32'(frame_err), 32'(e_fe));
        check("overrun",   32'(overrun),   32'(e_ov));
    endtask

    // Sends DATA_W data bits then one parity bit; with gaps, an idle cycle follows each bit.
    task automatic send_frame(input logic [DATA_W-1:0] word, input logic par,
                              input logic r, input logic gaps);
        for (int i = 0; i <= DATA_W; i++) begin
            step(1'b1, i == 0, (i == DATA_W) ? par : word[i], r);
            if (gaps && i != DATA_W) step(1'b0, 1'b0, 1'b0, r);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sin_valid = 1'b0;
        sin_start = 1'b0;
        sin_bit   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       v, s, b, r;
        logic       ev;
        logic [7:0] ed;
        logic       ep, ef, eo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic s, input logic b, input logic r,
                       input logic ev, input logic [7:0] ed,
                       input logic ep, input logic ef, input logic eo);
        vec_t t;
        t.v = v; t.s = s; t.b = b; t.r = r;
        t.ev = ev; t.ed = ed; t.ep = ep; t.ef = ef; t.eo = eo;
        vecs.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        logic       seen_ov;

        // Reset state
        do_reset();
        check("rst out_valid", 32'(out_valid), 0);
        check("rst out_data",  32'(out_data),  0);
        check("rst pulses",    32'({par_err, frame_err, overrun}), 0);

        // 0xA5 even parity (0), then 0x3C with wrong parity (1), then aborted frame + 0x7E
        w = 8'hA5;
        for (int i = 0; i < 8; i++) add(1'b1, i == 0, w[i], 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) add(1'b1, i == 0, w[i], 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b1, i == 0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        w = 8'h7E;
        for (int i = 0; i < 8; i++) add(1'b1, i == 0, w[i], 1'b1, 1'b0, 8'hA5, 1'b0, i == 0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            sin_valid = vecs[k].v;
            sin_start = vecs[k].s;
            sin_bit   = vecs[k].b;
            out_ready = vecs[k].r;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(vecs[k].ev));
            check($sformatf("vec%0d out_data", k),  32'(out_data),  32'(vecs[k].ed));
            check($sformatf("vec%0d pulses", k),
                  32'({par_err, frame_err, overrun}), 32'({vecs[k].ep, vecs[k].ef, vecs[k].eo}));
        end

        // Overrun: 0x11 waits unconsumed while 0x22 arrives and is dropped
        do_reset();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        check("ovr pulse", 32'(overrun), 1);
        check("ovr held data", 32'(out_data), 32'h11);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr consumed", 32'(out_valid), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr no 0x22", 32'(out_data), 32'h11);

        // Gapped 0x81 with parity 1: odd-parity instance accepts, even instance flags it
        do_reset();
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        check("odd out_valid", 32'(odd_valid), 1);
        check("odd out_data",  32'(odd_data),  32'h81);
        check("odd pulses",    32'({odd_par_err, odd_frame_err, odd_overrun}), 0);
        check("even par_err",  32'(par_err), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst odd valid", 32'(odd_valid), 0);
        check("async rst odd data",  32'(odd_data),  0);
        check("async rst pulses",
              32'({par_err, frame_err, overrun, odd_par_err, odd_frame_err, odd_overrun}), 0);
        do_reset();

        // Back-to-back frames with out_ready=1: one word per DATA_W+1 bits
        for (int f = 0; f < 4; f++) begin
            w = 8'(f * 37 + 5);
            send_frame(w, ^w, 1'b1, 1'b0);
            check("b2b word", 32'(out_data), 32'(w));
        end

        // Randomized traffic against the frame-level model
        do_reset();
        seen_ov = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic v, s, b, r;
            v = ($urandom_range(0, 3) != 0);
            s = v && ((m_len == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0));
            b = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 2) != 0);
            step(v, s, b, r);
            seen_ov |= overrun;
        end

`ifdef SPR_ERR_COUNT_EN
        do_reset();
        check("err_count reset", 32'(err_count), 0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("err_count one", 32'(err_count), 1);
        for (int f = 1; f < 300; f++) send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("err_count saturated", 32'(err_count), 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
